// File: rtl/cal_freqmeas_pkg.sv
// ---------------------------------------------------------------------------
// cal_pkg
// Shared definitions for the calibration-tone frequency measurement block:
// the measurement FSM state encoding, default sizing constants and a helper
// that turns the 4-bit period request into a period count (0 means 16).
// ---------------------------------------------------------------------------
package cal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } cal_state_e;

    localparam int CAL_CNT_W_DEFAULT   = 16;
    localparam int CAL_TIMEOUT_DEFAULT = 65535;

    // A request of 0 periods is encoded as 16 so the full 4-bit range is usable.
    function automatic logic [4:0] cal_n_decode(input logic [3:0] periods);
        return (periods == 4'd0) ? 5'd16 : {1'b0, periods};
    endfunction

endpackage

// File: rtl/cal_freqmeas_sync_edge.sv
// ---------------------------------------------------------------------------
// cal_sync_edge
// Brings the asynchronous calibration signal into the clk domain through a
// SYNC_STAGES-deep flop chain (2 or 3 stages), then one more flop so
// that a single-cycle rising-edge strobe can be formed.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset (clears every flop)
//   async_sig  asynchronous input signal
//   rise       one-cycle strobe on each synchronised 0->1 transition
// ---------------------------------------------------------------------------
module cal_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_sig,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_sig};
            sync_d  <= sync_ff[SYNC_STAGES-1];
        end
    end

    // Start and end edges of a measurement take the same path, so the
    // fixed latency cancels out of the period count.
    assign rise = sync_ff[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/cal_freqmeas.sv
// ---------------------------------------------------------------------------
// cal_freqmeas
// Measures the length of N periods of the returned calibration tone in
// system-clock cycles. After cal_start the block waits for a first rising
// edge, then counts clock cycles until N further rising edges have been
// seen. An inter-edge timeout flags a missing tone.
//
// Optional build macro: CAL_FREQMEAS_TOLCHECK_EN adds cal_expect/cal_tol
// inputs and a cal_mismatch result flag (|count - expect| > tol, overflow,
// or timeout).
//
// Ports:
//   cal_clkin    system clock
//   cal_reset    synchronous, active-high reset
//   cal_sig      asynchronous calibration signal
//   cal_start    start strobe, honoured in IDLE only
//   cal_abort    return to IDLE immediately, no result
//   cal_periods  number of periods N (0 = 16)
//   cal_count    measured cycles over N periods
//   cal_done     one-cycle pulse when results are updated
//   cal_busy     high while waiting for edges or measuring
//   cal_ovf      accumulator saturated
//   cal_tmo      edge timeout occurred
// ---------------------------------------------------------------------------
module cal_freqmeas
    import cal_pkg::*;
#(
    parameter int CNT_W       = CAL_CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = CAL_TIMEOUT_DEFAULT
) (
    input  logic             cal_clkin,
    input  logic             cal_reset,
    input  logic             cal_sig,
    input  logic             cal_start,
    input  logic             cal_abort,
    input  logic [3:0]       cal_periods,
    output logic [CNT_W-1:0] cal_count,
    output logic             cal_done,
    output logic             cal_busy,
    output logic             cal_ovf,
    output logic             cal_tmo
`ifdef CAL_FREQMEAS_TOLCHECK_EN
   ,input  logic [CNT_W-1:0] cal_expect,
    input  logic [7:0]       cal_tol,
    output logic             cal_mismatch
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);

    cal_state_e       state;
    logic [CNT_W-1:0] acc;
    logic             ovf_int;
    logic [4:0]       n_lat;
    logic [4:0]       edges_left;
    logic [TW-1:0]    tmo_cnt;
    logic             rise;
    logic             tmo_hit;

    cal_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (cal_clkin),
        .reset     (cal_reset),
        .async_sig (cal_sig),
        .rise      (rise)
    );

    // The counter clears on each rise; this cycle would make it reach TIMEOUT.
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    assign cal_busy = (state == ARM) || (state == MEAS);

`ifdef CAL_FREQMEAS_TOLCHECK_EN
    logic [CNT_W:0] diff;
    logic           mismatch_next;

    always_comb begin
        diff = '0;
        if (acc >= cal_expect)
            diff = {1'b0, acc} - {1'b0, cal_expect};
        else
            diff = {1'b0, cal_expect} - {1'b0, acc};
        // Widen both sides so any CNT_W compares safely against the 8-bit tolerance.
        mismatch_next = ovf_int ||
                        ({8'b0, diff} > {{(CNT_W+1){1'b0}}, cal_tol});
    end
`endif

    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            state      <= IDLE;
            acc        <= '0;
            ovf_int    <= 1'b0;
            n_lat      <= 5'd0;
            edges_left <= 5'd0;
            tmo_cnt    <= '0;
            cal_count  <= '0;
            cal_done   <= 1'b0;
            cal_ovf    <= 1'b0;
            cal_tmo    <= 1'b0;
`ifdef CAL_FREQMEAS_TOLCHECK_EN
            cal_mismatch <= 1'b0;
`endif
        end else if (cal_abort) begin
            // Abort drops the measurement; held results stay untouched.
            state    <= IDLE;
            cal_done <= 1'b0;
        end else begin
            cal_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cal_start) begin
                        n_lat   <= cal_n_decode(cal_periods);
                        acc     <= '0;
                        tmo_cnt <= '0;
                        ovf_int <= 1'b0;
                        state   <= ARM;
                    end
                end

                ARM: begin
                    if (rise) begin
                        acc        <= CNT_W'(1);
                        edges_left <= n_lat;
                        tmo_cnt    <= '0;
                        state      <= MEAS;
                    end else if (tmo_hit) begin
                        cal_count <= '0;
                        cal_ovf   <= 1'b0;
                        cal_tmo   <= 1'b1;
                        cal_done  <= 1'b1;
`ifdef CAL_FREQMEAS_TOLCHECK_EN
                        cal_mismatch <= 1'b1;
`endif
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                MEAS: begin
                    if (rise) begin
                        tmo_cnt <= '0;
                        if (edges_left == 5'd1) begin
                            // Terminating edge cycle is not counted, so acc
                            // already equals N periods; publish it now so the
                            // done pulse lands in the DONE cycle.
                            cal_count <= acc;
                            cal_ovf   <= ovf_int;
                            cal_tmo   <= 1'b0;
                            cal_done  <= 1'b1;
`ifdef CAL_FREQMEAS_TOLCHECK_EN
                            cal_mismatch <= mismatch_next;
`endif
                            state     <= DONE;
                        end else begin
                            edges_left <= edges_left - 5'd1;
                            if (acc == '1) ovf_int <= 1'b1;
                            else           acc     <= acc + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        cal_count <= '0;
                        cal_ovf   <= 1'b0;
                        cal_tmo   <= 1'b1;
                        cal_done  <= 1'b1;
`ifdef CAL_FREQMEAS_TOLCHECK_EN
                        cal_mismatch <= 1'b1;
`endif
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (acc == '1) ovf_int <= 1'b1;
                        else           acc     <= acc + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cal_freqmeas.sv
// ---------------------------------------------------------------------------
// tb_cal_freqmeas
// Two instances: a 16-bit one with a short edge timeout (100 cycles) for
// the functional cases, and an 8-bit one for accumulator saturation.
// Expected results are queued when a measurement is started and popped by
// a monitor whenever cal_done pulses.
// ---------------------------------------------------------------------------
module tb_cal_freqmeas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sig16, start16, abort16;
    logic [3:0]  per_n16;
    logic [15:0] count16;
    logic        done16, busy16, ovf16, tmo16;

    logic        sig8, start8, abort8;
    logic [3:0]  per_n8;
    logic [7:0]  count8;
    logic        done8, busy8, ovf8, tmo8;

`ifdef CAL_FREQMEAS_TOLCHECK_EN
    logic [15:0] expect16 = 16'd48;
    logic [7:0]  tol16    = 8'd2;
    logic        mm16;
    logic [7:0]  expect8  = 8'd0;
    logic [7:0]  tol8     = 8'd0;
    logic        mm8;
`endif

    cal_freqmeas #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(100)) dut16 (
        .cal_clkin   (clk),
        .cal_reset   (rst),
        .cal_sig     (sig16),
        .cal_start   (start16),
        .cal_abort   (abort16),
        .cal_periods (per_n16),
        .cal_count   (count16),
        .cal_done    (done16),
        .cal_busy    (busy16),
        .cal_ovf     (ovf16),
        .cal_tmo     (tmo16)
`ifdef CAL_FREQMEAS_TOLCHECK_EN
       ,.cal_expect  (expect16),
        .cal_tol     (tol16),
        .cal_mismatch(mm16)
`endif
    );

    cal_freqmeas #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(65535)) dut8 (
        .cal_clkin   (clk),
        .cal_reset   (rst),
        .cal_sig     (sig8),
        .cal_start   (start8),
        .cal_abort   (abort8),
        .cal_periods (per_n8),
        .cal_count   (count8),
        .cal_done    (done8),
        .cal_busy    (busy8),
        .cal_ovf     (ovf8),
        .cal_tmo     (tmo8)
`ifdef CAL_FREQMEAS_TOLCHECK_EN
       ,.cal_expect  (expect8),
        .cal_tol     (tol8),
        .cal_mismatch(mm8)
`endif
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic        ovf;
        logic        tmo;
        logic        mm;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    int errors = 0;
    int checks = 0;
    int done_seen16 = 0;
    int done_seen8  = 0;
    int done_cyc16  = 0;
    int cyc = 0;
    int t0  = 0;
    int n0  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected mismatch flag: timeout, overflow, or outside expect +/- tol.
    function automatic exp_t mk(input int c, input logic o, input logic t,
                                input int ex, input int tl);
        exp_t r;
        int   d;
        d = (c > ex) ? (c - ex) : (ex - c);
        r.cnt = 16'(c);
        r.ovf = o;
        r.tmo = t;
        r.mm  = t | o | (d > tl);
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done16) begin
            done_seen16++;
            done_cyc16 = cyc;
            if (q16.size() == 0) chk("d16_unexpected_done", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("d16_count", 32'(count16), 32'(e16.cnt));
                chk("d16_ovf", 32'(ovf16), 32'(e16.ovf));
                chk("d16_tmo", 32'(tmo16), 32'(e16.tmo));
`ifdef CAL_FREQMEAS_TOLCHECK_EN
                chk("d16_mismatch", 32'(mm16), 32'(e16.mm));
`endif
            end
        end
        if (!rst && done8) begin
            done_seen8++;
            if (q8.size() == 0) chk("d8_unexpected_done", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("d8_count", 32'(count8), 32'(e8.cnt));
                chk("d8_ovf", 32'(ovf8), 32'(e8.ovf));
                chk("d8_tmo", 32'(tmo8), 32'(e8.tmo));
`ifdef CAL_FREQMEAS_TOLCHECK_EN
                chk("d8_mismatch", 32'(mm8), 32'(e8.mm));
`endif
            end
        end
    end

    // Square-wave generators, clock-aligned so each period is exact.
    int per16 = 0, per8 = 0, ph16 = 0, ph8 = 0;
    initial begin
        sig16 = 1'b0;
        sig8  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (per16 == 0) begin sig16 = 1'b0; ph16 = 0; end
            else begin
                sig16 = (ph16 < per16 / 2);
                ph16  = (ph16 + 1 >= per16) ? 0 : ph16 + 1;
            end
            if (per8 == 0) begin sig8 = 1'b0; ph8 = 0; end
            else begin
                sig8 = (ph8 < per8 / 2);
                ph8  = (ph8 + 1 >= per8) ? 0 : ph8 + 1;
            end
        end
    end

    task automatic go16(input logic [3:0] n);
        per_n16 = n;
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        t0 = cyc;
    endtask

    task automatic go8(input logic [3:0] n);
        per_n8 = n;
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
    endtask

    task automatic wait_done16(input int limit, input string tag);
        int base = done_seen16;
        int k = 0;
        while (done_seen16 == base && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 32'(done_seen16 != base), 1);
    endtask

    task automatic wait_done8(input int limit, input string tag);
        int base = done_seen8;
        int k = 0;
        while (done_seen8 == base && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 32'(done_seen8 != base), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start16 = 1'b0; abort16 = 1'b0; per_n16 = 4'd0;
        start8  = 1'b0; abort8  = 1'b0; per_n8  = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_count16", 32'(count16), 0);
        chk("rst_done16",  32'(done16), 0);
        chk("rst_busy16",  32'(busy16), 0);
        chk("rst_ovf16",   32'(ovf16), 0);
        chk("rst_tmo16",   32'(tmo16), 0);
        chk("rst_count8",  32'(count8), 0);
        rst = 1'b0;

        // Period 12, N=4 -> 48
        per16 = 12;
        repeat (60) @(posedge clk);
        q16.push_back(mk(48, 0, 0, 48, 2));
        go16(4'd4);
        wait_done16(300, "A_done_arrived");
        @(negedge clk); #1;
        chk("A_busy_after_done", 32'(busy16), 0);
        chk("A_done_one_cycle", 32'(done16), 0);
        repeat (60) @(posedge clk);
        chk("A_single_done", 32'(done_seen16), 1);

        // N=0 means 16, period 10 -> 160
        per16 = 10;
        repeat (60) @(posedge clk);
        q16.push_back(mk(160, 0, 0, 48, 2));
        go16(4'd0);
        wait_done16(400, "B_done_arrived");

        // Abort mid-measurement: no done, results held
        per16 = 12;
        repeat (60) @(posedge clk);
        go16(4'd4);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy16), 1);
        abort16 = 1'b1;
        @(posedge clk); #1 abort16 = 1'b0;
        chk("abort_busy_after", 32'(busy16), 0);
        n0 = done_seen16;
        repeat (100) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_seen16), 32'(n0));
        chk("abort_count_kept", 32'(count16), 160);
        chk("abort_tmo_kept", 32'(tmo16), 0);

        // Signal stuck low -> timeout after 100 cycles
        per16 = 0;
        repeat (20) @(posedge clk);
        q16.push_back(mk(0, 0, 1, 48, 2));
        go16(4'd4);
        wait_done16(300, "tmo_done_arrived");
        chk("tmo_latency", 32'(done_cyc16 - t0), 100);
        chk("tmo_busy_after", 32'(busy16), 0);

        // 8-bit accumulator saturates: period 40, N=8 -> 255 with ovf
        per8 = 40;
        repeat (100) @(posedge clk);
        q8.push_back(mk(255, 1, 0, 0, 0));
        go8(4'd8);
        wait_done8(1000, "ovf_done_arrived");

        // Period 13, N=4 -> 52 (outside 48 +/- 2)
        per16 = 13;
        repeat (60) @(posedge clk);
        q16.push_back(mk(52, 0, 0, 48, 2));
        go16(4'd4);
        wait_done16(300, "P13_done_arrived");

        // Reset in the middle of a measurement clears held results
        per16 = 12;
        repeat (60) @(posedge clk);
        go16(4'd4);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_count16", 32'(count16), 0);
        chk("mrst_tmo16", 32'(tmo16), 0);
        chk("mrst_busy16", 32'(busy16), 0);
        chk("mrst_count8", 32'(count8), 0);
        chk("mrst_ovf8", 32'(ovf8), 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        chk("q16_drained", 32'(q16.size()), 0);
        chk("q8_drained", 32'(q8.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
